// File: rtl/snn_enc_pkg.sv
// ----------------------------------------------------------------------------
// snn_enc_pkg
// Shared types, widths and helper functions for the RGB rate-coding spike
// encoder (rgb_spike_encoder) and its LFSR sub-module (lfsr8).
// No ports; imported by the other design files.
// ----------------------------------------------------------------------------
package snn_enc_pkg;

    // Pseudo-random source: 8-bit Galois LFSR, taps 0xB8 (maximal, period 255)
    localparam int         LFSR_W    = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Counter widths: step count covers NUM_STEPS up to 1023, tick up to 65535
    localparam int STEP_W = 10;
    localparam int TICK_W = 16;

    // Per-channel 8-bit intensity
    typedef logic [7:0] intensity_t;

    // Window sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        OFFER = 2'd3
    } enc_state_t;

    // One Galois step: shift right, fold the taps in when a 1 falls out
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] shifted;
        shifted = s >> 1;
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    // Scale a raw 16-bit sensor word down and saturate to 8 bits
    function automatic intensity_t to_intensity(input logic [15:0] raw,
                                                input int unsigned shift);
        logic [15:0] scaled;
        scaled = raw >> shift;
        return (scaled > 16'd255) ? 8'hFF : scaled[7:0];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// ----------------------------------------------------------------------------
// lfsr8
// 8-bit Galois LFSR (taps 0xB8). Loads its seed on reset or on 'load',
// otherwise steps once per cycle while 'advance' is high.
// Ports:
//   clk      in   system clock
//   nrst     in   synchronous active-low reset (state returns to seed)
//   seed     in   8-bit nonzero seed value
//   load     in   reseed (has priority over advance)
//   advance  in   step the sequence by one
//   state    out  current LFSR value (never 0 for a nonzero seed)
// ----------------------------------------------------------------------------
module lfsr8
    import snn_enc_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [LFSR_W-1:0] seed,
    input  logic              load,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    // LFSR register: reseed on reset/load, step on advance, else hold
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= seed;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end else begin
            state <= state;
        end
    end

endmodule

// File: rtl/rgb_spike_encoder.sv
// ----------------------------------------------------------------------------
// rgb_spike_encoder
// Captures one RGB reading on a rising edge of the sensor's level ready,
// scales each channel to an 8-bit intensity, and rate-codes it over
// NUM_STEPS timesteps: per step, channel c spikes when lfsr_c <= intensity_c.
// Since each LFSR visits 1..255 exactly once per 255 steps, a 255-step window
// yields exactly 'intensity' spikes per channel.
// Ports:
//   clk           in   system clock
//   nrst          in   synchronous active-low reset
//   enable        in   gate for new captures (running window always finishes)
//   sens_ready    in   level ready from colour sensor (rising edge = reading)
//   red_in        in   raw 16-bit red word
//   green_in      in   raw 16-bit green word
//   blue_in       in   raw 16-bit blue word
//   spike         out  {r,g,b} spike bits of the offered timestep
//   spike_valid   out  timestep offered; held until accepted
//   spike_ready   in   consumer accepts on spike_valid && spike_ready
//   window_start  out  one-cycle pulse when a window begins
//   window_done   out  one-cycle pulse when the last step is accepted
//   busy          out  window in progress
//   overrun       out  sticky: a pending reading was overwritten
// ----------------------------------------------------------------------------
module rgb_spike_encoder
    import snn_enc_pkg::*;
#(
    parameter int unsigned SHIFT     = 8,
    parameter int unsigned NUM_STEPS = 255,
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [7:0]  SEED_R    = 8'h01,
    parameter logic [7:0]  SEED_G    = 8'h5A,
    parameter logic [7:0]  SEED_B    = 8'hC3
)(
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic        sens_ready,
    input  logic [15:0] red_in,
    input  logic [15:0] green_in,
    input  logic [15:0] blue_in,
    output logic [2:0]  spike,
    output logic        spike_valid,
    input  logic        spike_ready,
    output logic        window_start,
    output logic        window_done,
    output logic        busy,
    output logic        overrun
);

    // WAIT counts TICK_DIV-1 cycles; the counter runs 0..TICK_DIV-2 there.
    localparam int                TICK_LAST_INT = (TICK_DIV > 1) ? (int'(TICK_DIV) - 2) : 0;
    localparam logic [TICK_W-1:0] TICK_LAST     = TICK_W'(TICK_LAST_INT);
    localparam logic [STEP_W-1:0] LAST_STEP     = STEP_W'(NUM_STEPS - 1);
    // With TICK_DIV=1 the WAIT state is skipped entirely
    localparam bit                NO_WAIT       = (TICK_DIV <= 1);

    enc_state_t        state;
    logic              sens_ready_q;
    logic              rise;
    intensity_t        cap_r, cap_g, cap_b;
    intensity_t        slot_r, slot_g, slot_b;
    logic              slot_full;
    intensity_t        work_r, work_g, work_b;
    logic [STEP_W-1:0] step_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic              overrun_q;
    logic              accept;
    logic              last_step;
    logic              in_load;
    logic [7:0]        lfsr_r, lfsr_g, lfsr_b;

    // Capture qualification, channel scaling and handshake decode
    always_comb begin
        rise      = sens_ready & ~sens_ready_q & enable;
        cap_r     = to_intensity(red_in,   SHIFT);
        cap_g     = to_intensity(green_in, SHIFT);
        cap_b     = to_intensity(blue_in,  SHIFT);
        in_load   = (state == LOAD);
        accept    = (state == OFFER) & spike_ready;
        last_step = (step_cnt == LAST_STEP);
    end

    // Edge detector and one-deep pending slot with sticky overrun.
    // The slot is drained in LOAD; a rise in that same cycle refills it and
    // is not an overrun because the old contents are being consumed.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sens_ready_q <= 1'b0;
            slot_full    <= 1'b0;
            slot_r       <= 8'h00;
            slot_g       <= 8'h00;
            slot_b       <= 8'h00;
            overrun_q    <= 1'b0;
        end else begin
            sens_ready_q <= sens_ready;
            if (rise) begin
                slot_r    <= cap_r;
                slot_g    <= cap_g;
                slot_b    <= cap_b;
                slot_full <= 1'b1;
                if (slot_full && !in_load) begin
                    overrun_q <= 1'b1;
                end else begin
                    overrun_q <= overrun_q;
                end
            end else if (in_load) begin
                slot_full <= 1'b0;
            end else begin
                slot_full <= slot_full;
            end
        end
    end

    // Window sequencer: IDLE -> LOAD -> (WAIT ->) OFFER, repeated per step
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            step_cnt <= '0;
            tick_cnt <= '0;
            work_r   <= 8'h00;
            work_g   <= 8'h00;
            work_b   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (slot_full) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    work_r   <= slot_r;
                    work_g   <= slot_g;
                    work_b   <= slot_b;
                    step_cnt <= '0;
                    tick_cnt <= '0;
                    state    <= NO_WAIT ? OFFER : WAIT;
                end
                WAIT: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        state    <= OFFER;
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                OFFER: begin
                    if (spike_ready) begin
                        tick_cnt <= '0;
                        if (last_step) begin
                            state <= IDLE;
                        end else begin
                            step_cnt <= step_cnt + 10'd1;
                            state    <= NO_WAIT ? OFFER : WAIT;
                        end
                    end else begin
                        state <= OFFER;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One random source per channel; reseeded at every window start so
    // every window of the same reading produces the same spike train.
    lfsr8 u_lfsr_r (
        .clk     (clk),
        .nrst    (nrst),
        .seed    (SEED_R),
        .load    (in_load),
        .advance (accept),
        .state   (lfsr_r)
    );

    lfsr8 u_lfsr_g (
        .clk     (clk),
        .nrst    (nrst),
        .seed    (SEED_G),
        .load    (in_load),
        .advance (accept),
        .state   (lfsr_g)
    );

    lfsr8 u_lfsr_b (
        .clk     (clk),
        .nrst    (nrst),
        .seed    (SEED_B),
        .load    (in_load),
        .advance (accept),
        .state   (lfsr_b)
    );

    // Spike bits come from registered LFSR/intensity state, so they hold
    // steady for as long as the offer is pending; zero outside OFFER.
    always_comb begin
        spike = 3'b000;
        if (state == OFFER) begin
            spike = {(lfsr_r <= work_r), (lfsr_g <= work_g), (lfsr_b <= work_b)};
        end else begin
            spike = 3'b000;
        end
    end

    assign spike_valid  = (state == OFFER);
    assign window_start = in_load;
    assign window_done  = accept & last_step;
    assign busy         = (state != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: doc/rgb_spike_encoder.md
Name: rgb_spike_encoder

Overview:
Rate-codes one RGB reading from the colour-sensor front end into a window of spike timesteps for the SNN input layer. Sits directly downstream of colorlite: it captures the 16-bit channel words on the rising edge of that block's level ready signal. Each channel is scaled to an 8-bit intensity. Over NUM_STEPS timesteps, one spike bit per channel is emitted each step, with spike probability intensity/255, under a valid/ready handshake to the SNN core.

Parameters:
SHIFT, 8, right-shift applied to raw 16-bit channel before saturation to 8 bits (0..8)
NUM_STEPS, 255, timesteps per encoding window (1..1023)
TICK_DIV, 1, minimum clk cycles between successive timestep offers (1..65535)
SEED_R, 8'h01, LFSR seed for red (nonzero)
SEED_G, 8'h5A, LFSR seed for green (nonzero)
SEED_B, 8'hC3, LFSR seed for blue (nonzero)

Ports:
clk  in  1  system clock
nrst  in  1  reset, synchronous, active-low
enable  in  1  when 0: no new captures; an active window finishes normally
sens_ready  in  1  level ready from colour sensor; a rising edge marks a new reading
red_in  in  16  raw red word
green_in  in  16  raw green word
blue_in  in  16  raw blue word
spike  out  3  {r,g,b} spike bits for the current timestep
spike_valid  out  1  timestep offered; held until accepted
spike_ready  in  1  SNN accepts the timestep when spike_valid && spike_ready
window_start  out  1  one-cycle pulse on the cycle a window begins
window_done  out  1  one-cycle pulse on the cycle the last step is accepted
busy  out  1  window in progress
overrun  out  1  sticky; set when a pending reading is overwritten; cleared only by reset

Behaviour:
- Reset (nrst=0 at a clk edge): all outputs 0, FSM to IDLE, pending slot empty, edge-detect register 0.
- Capture: rise = sens_ready & ~sens_ready_q & enable. Each channel is computed as intensity = (raw >> SHIFT) > 255 ? 255 : (raw >> SHIFT)[7:0].
- Pending slot, one deep: a rise writes the three intensities to the slot. If the slot is already full, it is overwritten and overrun is set.
- FSM IDLE -> LOAD: when the slot is full. LOAD lasts 1 cycle:
  - moves slot to working regs and empties the slot
  - reseeds the LFSRs from SEED_*
  - clears step count and tick counter
  - pulses window_start; busy=1
  - a rise in the same cycle refills the slot
- LOAD -> WAIT: tick counter counts to TICK_DIV-1, then -> OFFER. With TICK_DIV=1, OFFER begins the cycle after LOAD or after an accept.
- OFFER:
  - spike_valid=1; spike[c] = (lfsr_c <= intensity_c), combinational on the registered LFSR state.
  - spike and spike_valid stay stable until accepted.
  - On accept: LFSRs advance one step, step count +1.
  - If step count reaches NUM_STEPS-1 on that accept: window_done pulses that cycle, then -> IDLE with busy=0 on the next cycle. Otherwise -> WAIT.
- Back-to-back windows: if the slot is full when leaving OFFER, go IDLE -> LOAD with a 1-cycle IDLE gap.
- LFSR: 8-bit Galois, taps 0xB8, maximal period 255, values 1..255. Per-step update is lfsr = lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1.
- Exactness: intensity 0 never spikes, 255 always spikes. With NUM_STEPS=255, the spike count over a window equals the intensity exactly.
- enable=0 mid-window: window completes; captures are blocked; an existing pending reading is still consumed.
- Reset mid-window: immediate abort, no window_done, pending reading discarded.
- Simultaneous rise and LOAD: slot is refilled with the new reading; overrun is not set.

Decomposition:
- Package snn_enc_pkg:
  - LFSR width 8 and taps 8'hB8
  - FSM state enum IDLE/LOAD/WAIT/OFFER
  - step-counter width 10, tick-counter width 16
  - intensity typedef logic [7:0]
- Sub-module lfsr8 (seed, load, advance, state): instantiated three times.

Test Plan:
- SHIFT=8, TICK_DIV=1, NUM_STEPS=255; red=0x6400, green=0x0000, blue=0xFF00; spike_ready=1 -> 255 accepts; per-channel spike counts 100/0/255; window_start once, window_done on the 255th accept.
- SHIFT=4: red=0x0FFF, green=0x1000, blue=0x0010 -> intensities 255/255/1; blue spikes on exactly one step, when lfsr_b==1.
- spike_ready toggled randomly, TICK_DIV=3 -> spike/spike_valid stable while unaccepted; consecutive offers ≥3 cycles apart; counts unchanged from the first scenario.
- Three sens_ready rises during one window -> overrun=1; next window uses the third reading, after a 1-cycle IDLE gap.
- nrst=0 at step 50 -> all outputs 0 next cycle, no window_done; a new rise after release starts a fresh window with reseeded LFSRs (identical spike sequence).
- enable=0 with a rise -> no capture, busy stays 0; enable=0 mid-window -> window completes.
